// File: rtl/batch_collector_if.sv
// batch_collector_if: sample stream, config and batch presentation signals of the collector
interface batch_collector_if #(
  parameter int IL    = 4,
  parameter int FL    = 16,
  parameter int size  = 16,
  parameter int width = $clog2(size)
);
  logic                          in_valid;
  logic [IL+FL-1:0]              in_data;
  logic                          in_last;
  logic                          in_ready;
  logic                          flush;
  logic                          cfg_we;
  logic [IL+FL-1:0]              cfg_gamma;
  logic [IL+FL-1:0]              cfg_beta;
  logic [1:0]                    fwd_state;
  logic [size-1:0][IL+FL-1:0]    batch;
  logic [width:0]                num;
  logic [IL+FL-1:0]              gamma;
  logic [IL+FL-1:0]              beta;
  logic                          input_ready;
  logic [15:0]                   batches_sent;
  modport master (
    output in_valid, in_data, in_last, flush, cfg_we, cfg_gamma, cfg_beta, fwd_state,
    input  in_ready, batch, num, gamma, beta, input_ready, batches_sent
  );
  modport slave (
    input  in_valid, in_data, in_last, flush, cfg_we, cfg_gamma, cfg_beta, fwd_state,
    output in_ready, batch, num, gamma, beta, input_ready, batches_sent
  );
endinterface

// File: rtl/batch_collector.sv
// batch_collector: ping-pong gathering of a sample stream into batches presented to the forward stage
module batch_collector #(
  parameter int IL    = 4,
  parameter int FL    = 16,
  parameter int size  = 16,
  parameter int width = $clog2(size)
) (
  input logic              clk,
  input logic              reset,
  batch_collector_if.slave bus
);
  localparam int W = IL + FL;
  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] FILLING = 2'd1;
  localparam logic [1:0] CLOSED  = 2'd2;
  logic [1:0]              st     [2];
  logic [size-1:0][W-1:0]  mem    [2];
  logic [width:0]          cnt    [2];
  logic [W-1:0]            g_snap [2];
  logic [W-1:0]            b_snap [2];
  logic [W-1:0]            sh_g, sh_b;
  logic                    wr_sel, rd_sel;
  logic                    wr_ok, take, close, accept, nxt_rd, pres;
  logic [width:0]          cn;
  assign bus.in_ready = wr_ok;
  // Write/close/accept decisions; a flush counts a sample taken on the same edge
  always_comb begin
    wr_ok  = st[wr_sel] != CLOSED;
    take   = bus.in_valid && wr_ok;
    cn     = cnt[wr_sel] + {{width{1'b0}}, take};
    close  = wr_ok && ((take && (bus.in_last || cn == (width+1)'(size))) || (bus.flush && cn != '0));
    accept = bus.input_ready && bus.fwd_state == 2'b00;
    nxt_rd = accept ? ~rd_sel : rd_sel;
    pres   = st[nxt_rd] == CLOSED;
  end
  // Buffer state: fill the write buffer, close it with a shadow snapshot, free the accepted one
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        st[i]     <= EMPTY;
        mem[i]    <= '0;
        cnt[i]    <= '0;
        g_snap[i] <= '0;
        b_snap[i] <= '0;
      end
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      sh_g   <= W'(1) << FL;
      sh_b   <= '0;
    end else begin
      if (bus.cfg_we) begin
        sh_g <= bus.cfg_gamma;
        sh_b <= bus.cfg_beta;
      end
      if (take) begin
        mem[wr_sel][cnt[wr_sel][width-1:0]] <= bus.in_data;
        cnt[wr_sel]                         <= cn;
        st[wr_sel]                          <= FILLING;
      end
      if (close) begin
        st[wr_sel]     <= CLOSED;
        g_snap[wr_sel] <= sh_g;
        b_snap[wr_sel] <= sh_b;
        wr_sel         <= ~wr_sel;
      end
      if (accept) begin
        st[rd_sel]  <= EMPTY;
        mem[rd_sel] <= '0;
        cnt[rd_sel] <= '0;
        rd_sel      <= ~rd_sel;
      end
    end
  // Presentation registers track the head buffer, switching to the other one right after an accept
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.input_ready  <= 1'b0;
      bus.batch        <= '0;
      bus.num          <= '0;
      bus.gamma        <= '0;
      bus.beta         <= '0;
      bus.batches_sent <= '0;
    end else begin
      bus.input_ready <= pres;
      bus.batch       <= pres ? mem[nxt_rd] : '0;
      bus.num         <= pres ? cnt[nxt_rd] : '0;
      bus.gamma       <= pres ? g_snap[nxt_rd] : '0;
      bus.beta        <= pres ? b_snap[nxt_rd] : '0;
      if (accept) bus.batches_sent <= bus.batches_sent + 16'd1;
    end
endmodule

// File: tb/tb_batch_collector.sv
// tb_batch_collector: directed checks of batch gathering, presentation, config snapshots and reset
module tb_batch_collector;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [15:0][19:0] exp_b;
  batch_collector_if #(.IL(4), .FL(16), .size(16)) bus ();
  batch_collector #(.IL(4), .FL(16), .size(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.flush    = 1'b0;
    bus.cfg_we   = 1'b0;
  endtask
  task automatic send(input logic [19:0] d, input logic l);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("send_timeout", 1, 0);
    step();
  endtask
  task automatic accept_one();
    bus.fwd_state = 2'b00;
    step();
    bus.fwd_state = 2'b01;
  endtask
  task automatic do_reset();
    idle();
    bus.fwd_state = 2'b01;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask
  initial begin
    idle();
    bus.in_data   = '0;
    bus.cfg_gamma = '0;
    bus.cfg_beta  = '0;
    bus.fwd_state = 2'b01;
    do_reset();
    check("rst_input_ready", bus.input_ready, 0);
    check("rst_num", bus.num, 0);
    check("rst_batch", bus.batch, 0);
    check("rst_sent", bus.batches_sent, 0);
    check("rst_in_ready", bus.in_ready, 1);
    // T1: five samples, last on fifth, forward idle
    bus.fwd_state = 2'b00;
    for (int i = 0; i < 5; i++) send(20'(i + 1), i == 4);
    idle();
    check("t1_not_yet", bus.input_ready, 0);
    step();
    exp_b = '0;
    for (int i = 0; i < 5; i++) exp_b[i] = 20'(i + 1);
    check("t1_ready", bus.input_ready, 1);
    check("t1_num", bus.num, 5);
    check("t1_batch", bus.batch, exp_b);
    check("t1_gamma_default", bus.gamma, 20'h10000);
    check("t1_beta_default", bus.beta, 0);
    step();
    check("t1_sent", bus.batches_sent, 1);
    check("t1_drop", bus.input_ready, 0);
    check("t1_num_drop", bus.num, 0);
    // T2: forty samples with forward busy
    do_reset();
    for (int i = 0; i < 32; i++) send(20'(i + 1), 1'b0);
    check("t2_full", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 20'd33;
    step();
    step();
    check("t2_stall", bus.in_ready, 0);
    check("t2_head_num", bus.num, 16);
    check("t2_head_first", bus.batch[0], 1);
    accept_one();
    exp_b = '0;
    for (int i = 0; i < 16; i++) exp_b[i] = 20'(i + 17);
    check("t2_in_ready_back", bus.in_ready, 1);
    check("t2_second", bus.batch, exp_b);
    check("t2_sent", bus.batches_sent, 1);
    for (int i = 32; i < 40; i++) send(20'(i + 1), 1'b0);
    idle();
    bus.flush = 1'b1;
    step();
    idle();
    accept_one();
    exp_b = '0;
    for (int i = 0; i < 8; i++) exp_b[i] = 20'(i + 33);
    check("t2_tail_num", bus.num, 8);
    check("t2_tail", bus.batch, exp_b);
    check("t2_sent2", bus.batches_sent, 2);
    // T3: gamma/beta snapshots, including cfg_we on the closing edge
    do_reset();
    bus.cfg_we = 1'b1; bus.cfg_gamma = 20'h20000; bus.cfg_beta = 20'hFFFFF;
    step();
    idle();
    send(20'd1, 1'b1);
    idle();
    bus.cfg_we = 1'b1; bus.cfg_gamma = 20'h08000; bus.cfg_beta = 20'h00003;
    step();
    idle();
    send(20'd2, 1'b1);
    idle();
    step();
    check("t3_a_gamma", bus.gamma, 20'h20000);
    check("t3_a_beta", bus.beta, 20'hFFFFF);
    accept_one();
    check("t3_b_gamma", bus.gamma, 20'h08000);
    check("t3_b_beta", bus.beta, 20'h00003);
    check("t3_b_data", bus.batch[0], 2);
    bus.cfg_we = 1'b1; bus.cfg_gamma = 20'h11111;
    send(20'd3, 1'b1);
    idle();
    accept_one();
    check("t3_c_old_gamma", bus.gamma, 20'h08000);
    send(20'd4, 1'b1);
    idle();
    accept_one();
    check("t3_d_new_gamma", bus.gamma, 20'h11111);
    // T4: flush behaviour and in_last on the sixteenth sample
    do_reset();
    bus.flush = 1'b1;
    step();
    idle();
    step();
    check("t4_flush_empty", bus.input_ready, 0);
    send(20'hFFFF1, 1'b0);
    send(20'hFFFF2, 1'b0);
    bus.flush = 1'b1;
    send(20'hFFFF3, 1'b0);
    idle();
    step();
    check("t4_flush_ready", bus.input_ready, 1);
    check("t4_flush_num", bus.num, 3);
    check("t4_flush_data", bus.batch[2], 20'hFFFF3);
    accept_one();
    for (int i = 0; i < 16; i++) send(20'(i + 100), i == 15);
    idle();
    step();
    check("t4_last16_num", bus.num, 16);
    check("t4_last16_end", bus.batch[15], 115);
    accept_one();
    check("t4_single_close", bus.input_ready, 0);
    check("t4_sent", bus.batches_sent, 2);
    // T5: accept of buffer 0 on the edge buffer 1 closes
    do_reset();
    for (int i = 0; i < 31; i++) send(20'(i + 1), 1'b0);
    bus.fwd_state = 2'b00;
    send(20'd32, 1'b0);
    bus.fwd_state = 2'b01;
    idle();
    check("t5_in_ready", bus.in_ready, 1);
    check("t5_sent", bus.batches_sent, 1);
    for (int n = 0; n < 4 && !bus.input_ready; n++) step();
    exp_b = '0;
    for (int i = 0; i < 16; i++) exp_b[i] = 20'(i + 17);
    check("t5_present", bus.input_ready, 1);
    check("t5_num", bus.num, 16);
    check("t5_batch", bus.batch, exp_b);
    // T6: asynchronous reset while presenting and mid-fill
    send(20'd200, 1'b0);
    send(20'd201, 1'b0);
    idle();
    #2 reset = 1'b1;
    #1;
    check("t6_input_ready", bus.input_ready, 0);
    check("t6_num", bus.num, 0);
    check("t6_batch", bus.batch, 0);
    check("t6_gamma", bus.gamma, 0);
    check("t6_sent", bus.batches_sent, 0);
    check("t6_in_ready", bus.in_ready, 1);
    #1 reset = 1'b0;
    step();
    send(20'd7, 1'b1);
    idle();
    step();
    check("t6_post_num", bus.num, 1);
    check("t6_post_data", bus.batch[0], 7);
    check("t6_post_gamma", bus.gamma, 20'h10000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
